bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter DW, default 128, meaning data width of the shared buffer word.
REQ-002 SHALL have parameter AW, default 9, meaning word-index width (512 words).
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning max consecutive locked grants while the other port waits.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 CLK  in  1  clock; all state on rising edge.
REQ-006 RSTN  in  1  asynchronous active-low reset.
REQ-007 req0, req1  in  1 each  access request, port 0 = stream loader, port 1 = NTT engine.
REQ-008 we0, we1  in  1 each  1 = write, 0 = read, qualified by reqN.
REQ-009 lock0, lock1  in  1 each  requester asks to keep ownership for a burst.
REQ-010 addr0, addr1  in  AW each  word index.
REQ-011 wdata0, wdata1  in  DW each  write data.
REQ-012 gnt0, gnt1  out  1 each  access accepted this cycle.
REQ-013 rvalid0, rvalid1  out  1 each  read data valid for that port this cycle.
REQ-014 rdata  out  DW  read data, shared by both ports, valid when rvalidN.
REQ-015 bram_EN  out  1  buffer enable.
REQ-016 bram_WE  out  4  buffer byte-lane write enable.
REQ-017 bram_A  out  13  buffer byte address.
REQ-018 bram_Di  out  DW  buffer write data.
REQ-019 bram_Do  in  DW  buffer read data, gated by current bram_EN, one cycle after address.

Function
REQ-020 Grant SHALL be combinational on the request cycle, with at most one of gnt0/gnt1 high per cycle.
REQ-021 Only one requester active: that port SHALL be granted.
REQ-022 Both requesting with no lock active: round-robin SHALL apply; grant goes to the port not served last; last-served pointer updates on every grant.
REQ-023 Lock state: when a granted port has lockN=1, it SHALL own the buffer on following cycles while reqN and lockN stay high.
REQ-024 Burst counter: counts consecutive locked grants; when it reaches MAX_BURST while the other port requests, ownership SHALL pass to the other port for at least one grant, and the counter SHALL clear.
REQ-025 Lock release: owner deasserting reqN or lockN SHALL release ownership that cycle; arbitration reverts to REQ-022.
REQ-026 Granted access SHALL drive bram_A = {addrN, 2'b00} and bram_Di = wdataN.
REQ-027 Granted write SHALL drive bram_WE = 4'hF; granted read and idle SHALL drive bram_WE = 4'h0.
REQ-028 rvalidN SHALL be a register set on the cycle after a granted read by port N; rdata = bram_Do, so read latency = 1 cycle.
REQ-029 bram_EN SHALL be 1 on any grant cycle and on any cycle where rvalid0 or rvalid1 is 1, because bram_Do is gated by current EN; otherwise 0.
REQ-030 A return-only cycle (rvalid high, no grant) SHALL drive bram_WE = 0 so no write occurs.
REQ-031 Back-to-back reads SHALL sustain one access per cycle; a write issued in a read-return cycle SHALL NOT corrupt rdata.
REQ-032 Port-1 read followed immediately by port-0 grant SHALL return data only on rvalid1 in the next cycle.

Reset
REQ-033 While RSTN=0, the following SHALL hold: gnt0 = gnt1 = 0 (forced); rvalid0 = rvalid1 = 0; bram_EN = 0; bram_WE = 0; bram_A = 0; burst counter = 0; lock owner = none; last-served pointer = port 1.
REQ-034 Reset asserted mid-burst or with a read pending SHALL discard the pending rvalid and lock; after release, the first arbitration tie SHALL go to port 0.

Verification
REQ-035 Port 0 write addr0=5, wdata0=A5..A5, then port 0 read addr0=5 -> bram_A=20, bram_WE=F, then rvalid0=1 with rdata=A5..A5 one cycle after the read grant.
REQ-036 req0=req1=1, no lock, for 4 cycles after reset -> grants 0,1,0,1.
REQ-037 lock1=1, req1 held, req0=1, MAX_BURST=16 -> 16 gnt1, then 1 gnt0, then port 1 resumes.
REQ-038 Port 1 read addr1=3 followed next cycle by port 0 write addr0=3 -> rvalid1=1 with old data, bram_EN=1, and the new data is readable afterwards.
REQ-039 Single read, then idle -> bram_EN high for 2 cycles, bram_WE=0 in both.
REQ-040 RSTN pulsed low while rvalid0 is pending and a lock is held -> no rvalid after reset, and the next tie grants port 0.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-port arbiter for a single shared block RAM: round-robin with optional
// lock bursts capped at MAX_BURST, one access per cycle, 1-cycle read return.
module bram_arbiter #(
  parameter int DW        = 128,
  parameter int AW        = 9,
  parameter int MAX_BURST = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          bram_EN,
  output logic [3:0]    bram_WE,
  output logic [12:0]   bram_A,
  output logic [DW-1:0] bram_Di,
  input  logic [DW-1:0] bram_Do
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } own_e;

  own_e          own_q, own_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          last_q, last_d;   // 1 = port 1 was served last
  logic          rvalid0_q, rvalid1_q;
  logic          g0, g1;
  logic          hold0, hold1, at_max;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      own_q     <= OWN_NONE;
      burst_q   <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      own_q     <= own_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
    end
  end

  always_comb begin
    own_d   = own_q;
    burst_d = burst_q;
    last_d  = last_q;
    g0      = 1'b0;
    g1      = 1'b0;
    hold0   = (own_q == OWN_P0) && req0 && lock0;
    hold1   = (own_q == OWN_P1) && req1 && lock1;
    at_max  = (burst_q >= BW'(MAX_BURST));

    if (hold0) begin
      // A capped burst yields exactly one grant to the waiting port.
      if (at_max && req1) begin
        g1      = 1'b1;
        burst_d = '0;
      end else begin
        g0      = 1'b1;
        burst_d = at_max ? burst_q : burst_q + BW'(1);
      end
    end else if (hold1) begin
      if (at_max && req0) begin
        g0      = 1'b1;
        burst_d = '0;
      end else begin
        g1      = 1'b1;
        burst_d = at_max ? burst_q : burst_q + BW'(1);
      end
    end else begin
      own_d   = OWN_NONE;
      burst_d = '0;
      if (req0 && (!req1 || last_q)) begin
        g0 = 1'b1;
      end else if (req1) begin
        g1 = 1'b1;
      end
      if (g0 && lock0) begin
        own_d   = OWN_P0;
        burst_d = BW'(1);
      end else if (g1 && lock1) begin
        own_d   = OWN_P1;
        burst_d = BW'(1);
      end
    end

    if (g0) begin
      last_d = 1'b0;
    end else if (g1) begin
      last_d = 1'b1;
    end
  end

  assign gnt0    = g0 & RSTN;
  assign gnt1    = g1 & RSTN;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = bram_Do;

  // The RAM output is gated by the current enable, so keep it on for returns.
  assign bram_EN = gnt0 | gnt1 | rvalid0_q | rvalid1_q;

  always_comb begin
    bram_A  = '0;
    bram_Di = '0;
    bram_WE = 4'h0;
    if (gnt0) begin
      bram_A  = 13'({addr0, 2'b00});
      bram_Di = wdata0;
      bram_WE = we0 ? 4'hF : 4'h0;
    end else if (gnt1) begin
      bram_A  = 13'({addr1, 2'b00});
      bram_Di = wdata1;
      bram_WE = we1 ? 4'hF : 4'h0;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Vector-table bench for bram_arbiter with a behavioural RAM, shadow memory
// and a read-return scoreboard queue.
module tb_bram_arbiter;

  localparam int DW = 128;
  localparam int AW = 9;

  logic          CLK, RSTN;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          bram_EN;
  logic [3:0]    bram_WE;
  logic [12:0]   bram_A;
  logic [DW-1:0] bram_Di, bram_Do;

  bram_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(16)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .bram_EN(bram_EN), .bram_WE(bram_WE),
    .bram_A(bram_A), .bram_Di(bram_Di), .bram_Do(bram_Do)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural RAM: read-first, registered output gated by the current enable.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_q;
  always @(posedge CLK) begin
    if (bram_EN) begin
      dout_q <= mem[bram_A[AW+1:2]];
      if (bram_WE == 4'hF) mem[bram_A[AW+1:2]] <= bram_Di;
    end
  end
  assign bram_Do = bram_EN ? dout_q : '0;

  typedef struct {
    logic          r0, w0, l0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1, l1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic          exp_rv0, exp_rv1;
  int            n_cmp, n_err;

  localparam logic [DW-1:0] PA5  = {16{8'hA5}};
  localparam logic [DW-1:0] POLD = {16{8'h3C}};
  localparam logic [DW-1:0] PNEW = {16{8'hC3}};

  function automatic vec_t mk(input logic r0, w0, l0, input int a0, input logic [DW-1:0] d0,
                              input logic r1, w1, l1, input int a1, input logic [DW-1:0] d1,
                              input logic g0, g1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = AW'(a0); v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = AW'(a1); v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic step(input vec_t v, input int idx);
    logic [DW-1:0] exp_data;
    logic [3:0]    exp_we;
    @(negedge CLK);
    req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
    #2;
    $display("vec %0d: req=%b%b gnt=%b%b rvalid=%b%b en=%b we=%h a=%0d",
             idx, v.r0, v.r1, gnt0, gnt1, rvalid0, rvalid1, bram_EN, bram_WE, bram_A);
    chk("gnt0", DW'(gnt0), DW'(v.g0));
    chk("gnt1", DW'(gnt1), DW'(v.g1));
    chk("rvalid0", DW'(rvalid0), DW'(exp_rv0));
    chk("rvalid1", DW'(rvalid1), DW'(exp_rv1));
    chk("bram_EN", DW'(bram_EN), DW'(v.g0 | v.g1 | exp_rv0 | exp_rv1));
    exp_we = ((v.g0 && v.w0) || (v.g1 && v.w1)) ? 4'hF : 4'h0;
    chk("bram_WE", DW'(bram_WE), DW'(exp_we));
    if (v.g0) begin
      chk("bram_A", DW'(bram_A), DW'({v.a0, 2'b00}));
      chk("bram_Di", bram_Di, v.d0);
    end else if (v.g1) begin
      chk("bram_A", DW'(bram_A), DW'({v.a1, 2'b00}));
      chk("bram_Di", bram_Di, v.d1);
    end
    if (exp_rv0 || exp_rv1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", DW'(0), DW'(1));
      end else begin
        exp_data = sb.pop_front();
        chk("rdata", rdata, exp_data);
      end
    end
    exp_rv0 = v.g0 && !v.w0;
    exp_rv1 = v.g1 && !v.w1;
    if (v.g0 && v.w0) shadow[v.a0] = v.d0;
    if (v.g1 && v.w1) shadow[v.a1] = v.d1;
    if (exp_rv0) sb.push_back(shadow[v.a0]);
    if (exp_rv1) sb.push_back(shadow[v.a1]);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    exp_rv0 = 0; exp_rv1 = 0;
    drive_idle();
    RSTN = 1'b0;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    #3;
    chk("rst_gnt0", DW'(gnt0), DW'(0));
    chk("rst_gnt1", DW'(gnt1), DW'(0));
    chk("rst_rvalid", DW'({rvalid0, rvalid1}), DW'(0));
    chk("rst_en", DW'(bram_EN), DW'(0));
    chk("rst_we", DW'(bram_WE), DW'(0));
    chk("rst_a", DW'(bram_A), DW'(0));
    @(posedge CLK); @(posedge CLK); #1;
    RSTN = 1'b1;
    drive_idle();

    // Round-robin ties right after reset (writes to 10/11 seed later reads).
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,1,0, 10, DW'(100+i), 1,1,0, 11, DW'(200+i), (i%2)==0, (i%2)==1));
    // Write then read word 5, then two idle cycles.
    vecs.push_back(mk(1,1,0, 5, PA5,  0,0,0, 0, '0, 1,0));
    vecs.push_back(mk(1,0,0, 5, '0,   0,0,0, 0, '0, 1,0));
    vecs.push_back(mk(0,0,0, 0, '0,   0,0,0, 0, '0, 0,0));
    vecs.push_back(mk(0,0,0, 0, '0,   0,0,0, 0, '0, 0,0));
    // Port 1 read of word 3 followed by port 0 write of word 3.
    vecs.push_back(mk(0,0,0, 0, '0,   1,1,0, 3, POLD, 0,1));
    vecs.push_back(mk(0,0,0, 0, '0,   1,0,0, 3, '0,   0,1));
    vecs.push_back(mk(1,1,0, 3, PNEW, 0,0,0, 0, '0,   1,0));
    vecs.push_back(mk(0,0,0, 0, '0,   1,0,0, 3, '0,   0,1));
    vecs.push_back(mk(0,0,0, 0, '0,   0,0,0, 0, '0,   0,0));
    // Back-to-back reads across both ports.
    vecs.push_back(mk(1,0,0, 10, '0,  0,0,0, 0, '0,   1,0));
    vecs.push_back(mk(1,0,0, 10, '0,  1,0,0, 11, '0,  0,1));
    vecs.push_back(mk(1,0,0, 10, '0,  0,0,0, 0, '0,   1,0));
    vecs.push_back(mk(0,0,0, 0, '0,   0,0,0, 0, '0,   0,0));
    vecs.push_back(mk(0,0,0, 0, '0,   0,0,0, 0, '0,   0,0));
    // Lock hold beats round-robin; dropping lock releases it at once.
    vecs.push_back(mk(1,1,1, 20, DW'(1), 0,0,0, 0, '0,      1,0));
    vecs.push_back(mk(1,1,1, 20, DW'(2), 1,1,0, 21, DW'(3), 1,0));
    vecs.push_back(mk(1,1,0, 20, DW'(4), 1,1,0, 21, DW'(5), 0,1));
    vecs.push_back(mk(1,1,0, 20, DW'(6), 1,1,0, 21, DW'(7), 1,0));
    vecs.push_back(mk(0,0,0, 0, '0,      0,0,0, 0, '0,      0,0));
    // Burst cap: 16 locked port-1 grants, one port-0 grant, port 1 resumes.
    vecs.push_back(mk(0,0,0, 0, '0,      1,1,1, 40, DW'(400), 0,1));
    for (int i = 1; i < 16; i++)
      vecs.push_back(mk(1,1,0, 50, DW'(500+i), 1,1,1, 40+i, DW'(400+i), 0,1));
    vecs.push_back(mk(1,1,0, 50, DW'(600), 1,1,1, 60, DW'(700), 1,0));
    vecs.push_back(mk(1,1,0, 50, DW'(601), 1,1,1, 61, DW'(701), 0,1));
    vecs.push_back(mk(0,0,0, 0, '0,        0,0,0, 0, '0,        0,0));
    // Locked read by port 0, leaving rvalid0 pending for the reset test.
    vecs.push_back(mk(1,0,1, 5, '0,        0,0,0, 0, '0,        1,0));

    foreach (vecs[i]) step(vecs[i], i);

    // Reset while rvalid0 is pending and port 0 holds the lock.
    @(negedge CLK);
    req0 = 1; lock0 = 1; we0 = 0; req1 = 1; lock1 = 1; we1 = 0;
    #2;
    chk("rv_pending", DW'(rvalid0), DW'(1));
    RSTN = 1'b0;
    #1;
    chk("midrst_gnt", DW'({gnt0, gnt1}), DW'(0));
    chk("midrst_rvalid", DW'({rvalid0, rvalid1}), DW'(0));
    chk("midrst_en", DW'(bram_EN), DW'(0));
    chk("midrst_a", DW'(bram_A), DW'(0));
    sb.delete();
    exp_rv0 = 0; exp_rv1 = 0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    drive_idle();
    step(mk(1,1,0, 30, DW'(9), 1,1,0, 31, DW'(8), 1,0), 100);
    step(mk(1,1,0, 30, DW'(7), 1,1,0, 31, DW'(6), 0,1), 101);
    step(mk(0,0,0, 0, '0,      0,0,0, 0, '0,      0,0), 102);
    chk("sb_empty", DW'(sb.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
